// File: rtl/race_game_controller.sv
// Per-frame race game sequencer: lane moves, enemy descent/respawn, collision, score and speed ramp.
// Buttons are synchronized and latched as sticky presses that are consumed on frame_tick.
module race_game_controller #(
  parameter int unsigned LANE0_X      = 197,
  parameter int unsigned LANE1_X      = 279,
  parameter int unsigned LANE2_X      = 361,
  parameter int unsigned PLAYER_Y     = 357,
  parameter int unsigned CAR_H        = 121,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned SPEED_INIT   = 2,
  parameter int unsigned SPEED_MAX    = 12,
  parameter int unsigned SPEED_STEP   = 4,
  parameter int unsigned CRASH_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic [9:0] enemy_x,
  output logic [9:0] enemy_y,
  output logic [7:0] score,
  output logic [3:0] speed,
  output logic [1:0] state,
  output logic       crash_blink
);

  localparam int unsigned CNT_W = $clog2(CRASH_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       plane_q, plane_d, elane_q, elane_d;
  logic [9:0]       ey_d;
  logic [7:0]       score_d;
  logic [3:0]       speed_d;
  logic             blink_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sync1_q, sync2_q, sync3_q, pend_q, pend_d, pend_eff;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [10:0]      ny;
  logic [1:0]       rnd_lane;

  function automatic logic [9:0] lane_x(input logic [1:0] lane);
    case (lane)
      2'd0:    lane_x = 10'(LANE0_X);
      2'd2:    lane_x = 10'(LANE2_X);
      default: lane_x = 10'(LANE1_X);
    endcase
  endfunction

  assign player_y = 10'(PLAYER_Y);
  assign state    = state_q;

  // State and datapath registers; button bits are {start, right, left}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      plane_q     <= 2'd1;
      elane_q     <= 2'd0;
      player_x    <= 10'(LANE1_X);
      enemy_x     <= 10'(LANE0_X);
      enemy_y     <= 10'd0;
      score       <= 8'd0;
      speed       <= 4'(SPEED_INIT);
      crash_blink <= 1'b0;
      cnt_q       <= '0;
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      sync3_q     <= 3'b000;
      pend_q      <= 3'b000;
      lfsr_q      <= 8'hA5;
    end else begin
      state_q     <= state_d;
      plane_q     <= plane_d;
      elane_q     <= elane_d;
      player_x    <= lane_x(plane_d);
      enemy_x     <= lane_x(elane_d);
      enemy_y     <= ey_d;
      score       <= score_d;
      speed       <= speed_d;
      crash_blink <= blink_d;
      cnt_q       <= cnt_d;
      sync1_q     <= {start, right, left};
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      pend_q      <= pend_d;
      lfsr_q      <= lfsr_d;
    end
  end

  // Next-state and per-frame game update
  always_comb begin
    state_d  = state_q;
    plane_d  = plane_q;
    elane_d  = elane_q;
    ey_d     = enemy_y;
    score_d  = score;
    speed_d  = speed;
    blink_d  = crash_blink;
    cnt_d    = cnt_q;
    pend_eff = pend_q | (sync2_q & ~sync3_q);
    pend_d   = pend_eff;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rnd_lane = (lfsr_q[1:0] == 2'd3) ? 2'd1 : lfsr_q[1:0];
    ny       = 11'(enemy_y) + 11'(speed);

    if (frame_tick) begin
      pend_d = 3'b000;
      case (state_q)
        IDLE: begin
          if (pend_eff[2]) state_d = PLAY;
        end
        PLAY: begin
          if (pend_eff[0] && !pend_eff[1] && plane_q != 2'd0)
            plane_d = plane_q - 2'd1;
          else if (pend_eff[1] && !pend_eff[0] && plane_q != 2'd2)
            plane_d = plane_q + 2'd1;

          if (ny >= 11'(SCREEN_H)) begin
            ey_d    = 10'd0;
            elane_d = rnd_lane;
            score_d = (score == 8'hFF) ? score : score + 8'd1;
            if (score_d != 8'd0 && (score_d % 8'(SPEED_STEP)) == 8'd0 &&
                speed != 4'(SPEED_MAX))
              speed_d = speed + 4'd1;
          end else begin
            ey_d = ny[9:0];
          end

          // A respawned enemy sits at y=0, which is always outside the collision window
          if (elane_d == plane_d && ey_d > 10'(PLAYER_Y - CAR_H) &&
              ey_d < 10'(PLAYER_Y + CAR_H)) begin
            state_d = CRASH;
            cnt_d   = CNT_W'(CRASH_FRAMES);
            blink_d = 1'b1;
          end
        end
        CRASH: begin
          blink_d = ~crash_blink;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = OVER;
            blink_d = 1'b0;
          end
        end
        OVER: begin
          if (pend_eff[2]) begin
            state_d = PLAY;
            plane_d = 2'd1;
            elane_d = 2'd0;
            ey_d    = 10'd0;
            score_d = 8'd0;
            speed_d = 4'(SPEED_INIT);
            blink_d = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_race_game_controller.sv
// Directed bench for race_game_controller: moves, descent/wrap, score/speed ramp, crash, restart, async reset.
module tb_race_game_controller;

  logic       clk = 1'b0;
  logic       reset, frame_tick, left, right, start;
  logic [9:0] player_x, player_y, enemy_x, enemy_y;
  logic [7:0] score;
  logic [3:0] speed;
  logic [1:0] state;
  logic       crash_blink;

  int checks = 0;
  int errors = 0;

  race_game_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .left(left), .right(right), .start(start),
    .player_x(player_x), .player_y(player_y), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .score(score), .speed(speed), .state(state), .crash_blink(crash_blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lx(input int lane);
    case (lane)
      0:       lx = 197;
      2:       lx = 361;
      default: lx = 279;
    endcase
  endfunction

  function automatic int lane_of(input int x);
    case (x)
      197:     lane_of = 0;
      279:     lane_of = 1;
      361:     lane_of = 2;
      default: lane_of = 3;
    endcase
  endfunction

  // One-cycle frame_tick; returns at the negedge after the update edge
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  // Short press long enough to pass the synchronizer and latch a pending flag
  task automatic press(input logic l, input logic r, input logic s);
    @(negedge clk) begin left = l; right = r; start = s; end
    repeat (4) @(negedge clk);
    left = 1'b0; right = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_px"}, 32'(player_x), 279);
    check({tag, "_ex"}, 32'(enemy_x), 197);
    check({tag, "_ey"}, 32'(enemy_y), 0);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_speed"}, 32'(speed), 2);
    check({tag, "_blink"}, 32'(crash_blink), 0);
  endtask

  int p, e, s, n, sc_prev, sc;

  initial begin
    reset = 1'b1; frame_tick = 1'b0; left = 1'b0; right = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    check("player_y", 32'(player_y), 357);
    reset = 1'b0;

    // IDLE ignores ticks until start is pressed
    tick();
    check("idle_no_start", 32'(state), 0);
    press(1'b0, 1'b0, 1'b1);
    tick();
    check("start_state", 32'(state), 1);
    check("start_px", 32'(player_x), 279);
    check("start_ex", 32'(enemy_x), 197);
    check("start_ey", 32'(enemy_y), 0);
    check("start_speed", 32'(speed), 2);

    // Lane moves: held left, simultaneous presses, held right counts once, saturation
    @(negedge clk) left = 1'b1;
    repeat (4) @(negedge clk);
    tick();
    check("hold_left_1", 32'(player_x), 197);
    tick();
    tick();
    check("hold_left_3", 32'(player_x), 197);
    left = 1'b0;
    press(1'b1, 1'b1, 1'b0);
    tick();
    check("both_lane0", 32'(player_x), 197);
    @(negedge clk) right = 1'b1;
    repeat (4) @(negedge clk);
    tick();
    check("hold_right_1", 32'(player_x), 279);
    tick();
    check("hold_right_once", 32'(player_x), 279);
    right = 1'b0;
    press(1'b0, 1'b1, 1'b0);
    tick();
    check("right_2", 32'(player_x), 361);
    press(1'b0, 1'b1, 1'b0);
    tick();
    check("right_sat", 32'(player_x), 361);
    press(1'b1, 1'b1, 1'b0);
    tick();
    check("both_lane2", 32'(player_x), 361);
    check("ey_after_9", 32'(enemy_y), 18);

    // Crash 1: player joins enemy lane 0, boundary at y=236 vs 238
    press(1'b1, 1'b0, 1'b0);
    tick();
    check("left_to_1", 32'(player_x), 279);
    press(1'b1, 1'b0, 1'b0);
    tick();
    check("left_to_0", 32'(player_x), 197);
    check("ey_after_11", 32'(enemy_y), 22);
    repeat (107) tick();
    check("ey_236", 32'(enemy_y), 236);
    check("no_crash_236", 32'(state), 1);
    tick();
    check("crash_ey", 32'(enemy_y), 238);
    check("crash_state", 32'(state), 2);
    check("crash_blink", 32'(crash_blink), 1);
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) press(1'b1, 1'b1, 1'b0);
      tick();
      if (k < 60) begin
        check("crash_hold", 32'(state), 2);
        check("blink_toggle", 32'(crash_blink), (k % 2 == 0) ? 1 : 0);
      end else begin
        check("over_state", 32'(state), 3);
        check("over_blink", 32'(crash_blink), 0);
      end
    end
    check("frozen_ey", 32'(enemy_y), 238);
    check("frozen_px", 32'(player_x), 197);
    check("frozen_ex", 32'(enemy_x), 197);
    tick();
    check("over_no_start", 32'(state), 3);
    press(1'b0, 1'b1, 1'b0);
    tick();
    check("over_px_held", 32'(player_x), 197);
    press(1'b0, 1'b0, 1'b1);
    tick();
    check("restart_state", 32'(state), 1);
    check("restart_px", 32'(player_x), 279);
    check("restart_ex", 32'(enemy_x), 197);
    check("restart_ey", 32'(enemy_y), 0);

    // First pass at speed 2 wraps on the 240th tick
    repeat (239) tick();
    check("ey_478", 32'(enemy_y), 478);
    check("score_pre_wrap", 32'(score), 0);
    tick();
    check("wrap_ey", 32'(enemy_y), 0);
    check("wrap_score", 32'(score), 1);
    e = lane_of(32'(enemy_x));
    check("wrap_ex_valid", 32'(e < 3), 1);
    p = 1;

    // Remaining passes with dodging; score saturates at 255, speed ramps to 12
    for (int k = 2; k <= 257; k++) begin
      sc_prev = (k - 1 > 255) ? 255 : k - 1;
      s = 2 + sc_prev / 4;
      if (s > 12) s = 12;
      n = (480 + s - 1) / s;
      for (int i = 0; i < n; i++) begin
        if (i == 0 && e == p) begin
          if (p == 0) begin press(1'b0, 1'b1, 1'b0); p = 1; end
          else begin press(1'b1, 1'b0, 1'b0); p = p - 1; end
          tick();
          check("dodge_px", 32'(player_x), lx(p));
        end else begin
          tick();
        end
        if (i == n - 2) begin
          check("pass_score_pre", 32'(score), sc_prev);
          check("pass_ey_pre", 32'(enemy_y), (n - 1) * s);
        end
      end
      sc = (k > 255) ? 255 : k;
      check("pass_score", 32'(score), sc);
      check("pass_speed", 32'(speed), (2 + sc / 4 > 12) ? 12 : 2 + sc / 4);
      check("pass_ey_wrap", 32'(enemy_y), 0);
      check("pass_state", 32'(state), 1);
      e = lane_of(32'(enemy_x));
      check("pass_ex_valid", 32'(e < 3), 1);
    end

    // Crash 2 at speed 12: steer into the enemy lane; first y past 236 is 240
    for (int j = 0; j < 2; j++) begin
      if (p < e) begin press(1'b0, 1'b1, 1'b0); p = p + 1; tick(); end
      else if (p > e) begin press(1'b1, 1'b0, 1'b0); p = p - 1; tick(); end
    end
    for (int i = 0; i < 40; i++) begin
      if (state == 2'd2) break;
      tick();
    end
    check("crash2_state", 32'(state), 2);
    check("crash2_ey", 32'(enemy_y), 240);
    check("crash2_blink", 32'(crash_blink), 1);
    check("crash2_score", 32'(score), 255);
    repeat (60) tick();
    check("over2_state", 32'(state), 3);
    check("over2_score", 32'(score), 255);
    press(1'b0, 1'b0, 1'b1);
    tick();
    check("restart2_state", 32'(state), 1);
    check("restart2_score", 32'(score), 0);
    check("restart2_speed", 32'(speed), 2);
    check("restart2_ey", 32'(enemy_y), 0);
    check("restart2_px", 32'(player_x), 279);
    check("restart2_ex", 32'(enemy_x), 197);

    // Crash 3, then asynchronous reset between clock edges with a start press pending
    press(1'b1, 1'b0, 1'b0);
    tick();
    check("c3_px", 32'(player_x), 197);
    repeat (117) tick();
    check("c3_ey_236", 32'(enemy_y), 236);
    tick();
    check("c3_state", 32'(state), 2);
    press(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    @(negedge clk) reset = 1'b0;
    tick();
    check("no_pend_after_reset", 32'(state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_game_controller.md
Name: race_game_controller

Overview:
- Sequences one race round per video frame: player lane changes, enemy car descent and respawn, collision detection, score and speed ramp.
- Sits between the button inputs and the pixel-compositing logic. It replaces the free-running player-offset logic on the divided clock.
- Supplies player_x, enemy_x and enemy_y to the sprite compositor, and score and state to display logic.
- All game updates happen on a one-cycle frame_tick pulse, issued by VGA logic at the start of vertical blanking.

Parameters:
LANE0_X, 197, player/enemy x for lane 0 (left)
LANE1_X, 279, x for lane 1 (center)
LANE2_X, 361, x for lane 2 (right)
PLAYER_Y, 357, fixed player top row
CAR_H, 121, sprite height in lines
SCREEN_H, 480, visible lines; enemy respawns at or beyond this
SPEED_INIT, 2, initial enemy lines/frame
SPEED_MAX, 12, speed ceiling
SPEED_STEP, 4, points per +1 speed
CRASH_FRAMES, 60, frames spent in CRASH before OVER

Ports:
clk  in  1  pixel-domain clock (vga_clk)
reset  in  1  asynchronous, active-high; clears all state
frame_tick  in  1  one-cycle pulse per frame, synchronous to clk
left  in  1  raw button, asynchronous
right  in  1  raw button, asynchronous
start  in  1  raw button, asynchronous
player_x  out  10  player sprite left column
player_y  out  10  constant PLAYER_Y
enemy_x  out  10  enemy sprite left column
enemy_y  out  10  enemy sprite top row
score  out  8  enemies passed, saturating
speed  out  4  current enemy speed
state  out  2  0=IDLE 1=PLAY 2=CRASH 3=OVER
crash_blink  out  1  toggles each frame in CRASH; 0 otherwise

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, player lane 1 (player_x=279), enemy lane 0 (enemy_x=197), enemy_y=0.
  - score=0, speed=SPEED_INIT, crash_blink=0, crash counter=0.
  - Pending flags cleared, LFSR=8'hA5.
- Inputs:
  - left, right and start each pass through a 2-FF synchronizer.
  - A rising edge of the synchronized signal sets a sticky pending flag.
  - Flags are consumed and cleared only on frame_tick.
  - A press held across frames counts once.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, advances every clk.
  - New lane = lfsr[1:0]; the value 3 maps to lane 1.
- Output timing: all outputs are registered and update one cycle after the frame_tick that caused the change.
- IDLE: frame_tick with start pending -> PLAY; enemy_y stays 0.
- PLAY, on frame_tick, evaluated in this order:
  1. Move:
     - pend_left only: lane-1, saturating at 0.
     - pend_right only: lane+1, saturating at 2.
     - Both pending: no move.
     - All pending flags are cleared.
  2. Descent: ny = enemy_y + speed, computed 11 bits wide.
     - If ny >= SCREEN_H: enemy_y=0, enemy lane from LFSR, score+1 (saturating at 255).
     - When the new score is a nonzero multiple of SPEED_STEP, speed+1 (saturating at SPEED_MAX).
     - Otherwise enemy_y=ny.
  3. Collision, using post-update values: enemy lane == player lane AND enemy_y > PLAYER_Y-CAR_H (236) AND enemy_y < PLAYER_Y+CAR_H.
     - On collision: state=CRASH, crash counter=CRASH_FRAMES, crash_blink=1.
     - A freshly respawned enemy (y=0) never collides.
- CRASH:
  - Positions frozen; pending flags still cleared each tick.
  - Each tick: crash_blink toggles and counter-1.
  - Counter reaching 0 -> OVER, crash_blink=0.
- OVER:
  - Positions and score held.
  - frame_tick with start pending reinitializes to the reset values (LFSR excepted), then state=PLAY.
- frame_tick absent: no state, position or score changes; only the synchronizers, pending flags and LFSR advance.
- Mid-operation reset: immediate return to reset values regardless of state; no pending flag survives.

Test Plan:
- Reset, then pulse start and one frame_tick -> state=1, player_x=279, enemy_x=197, enemy_y=0, speed=2.
- In PLAY, hold left for 3 frames then release -> player_x=197 after one tick and stays 197. Then left+right in the same frame -> unchanged. Then right twice over two frames -> 361, with a third right staying 361.
- Player in lane 1, enemy lane 0, run 240 ticks -> enemy wraps 478->0, score=1, enemy_x in {197,279,361}. After score reaches 4 -> speed=3.
- Force player lane = enemy lane 0 and tick until enemy_y=238 -> state=2 on that tick, crash_blink=1. Blink toggles for 60 ticks, then state=3 with positions frozen.
- In OVER, press start and tick -> state=1, score=0, speed=2, enemy_y=0, player_x=279.
- Assert reset asynchronously mid-CRASH (no clk edge) -> outputs reach reset values immediately. Score saturation: preload or run past 255 passes -> score holds at 255.
